instr_fetch_unit: RTL

//  Initiator side of the instruction-memory read interface. Holds the fetch PC.

---
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, zero-latency imem read and a
// prefetch FIFO toward decode, flushed and restarted on redirect.
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect_valid,
  input  logic [ADDR_W+1:0]       redirect_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [31:0]             instr,
  output logic [ADDR_W+1:0]       instr_pc,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int PW = ADDR_W + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [31:0]   word;
    logic [PW-1:0] pc;
  } entry_t;

  logic [PW-1:0]    fetch_pc_q;
  logic [PW-1:0]    fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  entry_t           fifo_q [DEPTH];
  entry_t           wr_entry_d;
  entry_t           head;
  logic             pop;
  logic             push;

  always_comb begin
    pop  = instr_valid & instr_ready;
    push = ~redirect_valid & ((level_q != FULL) | pop);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    wr_entry_d = '{word: imem_rdata, pc: fetch_pc_q};
    if (redirect_valid) begin
      // Flush wins over any pop; the head stays visible this cycle only.
      fetch_pc_d = {redirect_pc[PW-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + PW'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: level_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= wr_entry_d;
    end
  end

  always_comb begin
    head        = fifo_q[rd_ptr_q];
    instr_valid = (level_q != '0);
    instr       = instr_valid ? head.word : '0;
    instr_pc    = instr_valid ? head.pc : '0;
    fifo_level  = level_q;
    imem_addr   = fetch_pc_q[PW-1:2];
  end

endmodule
